// File: rtl/param_select_sorter.sv
// -----------------------------------------------------------------------------
// param_select_sorter
//
// In-place selection sorter over a DEPTH = 2**AW entry, W-bit register-array
// memory. While idle the host loads and reads the memory through a simple
// addr/wr port (1-cycle registered read, read-old-on-collision). A start
// pulse sorts the memory ascending or descending, then the block returns to
// ready with a one-cycle done pulse.
//
// Optional feature (macro SORTER_SWAPCNT_EN): adds output 'swaps' (AW+1 bits)
// counting the swaps performed by the current/last sort.
//
// Ports:
//   clk      in   clock, all state changes on rising edge
//   nrst     in   asynchronous active-low reset
//   start    in   begin sort (honoured only while ready=1)
//   descend  in   0 = ascending, 1 = descending, sampled with start
//   ready    out  1 = idle, host port active
//   done     out  one-cycle pulse as ready returns after a sort
//   wr       in   host write strobe (idle only)
//   addr     in   host read/write address, AW bits
//   datain   in   host write data, W bits
//   dataout  out  registered host read data, W bits
//   swaps    out  swap count, AW+1 bits (SORTER_SWAPCNT_EN only)
// -----------------------------------------------------------------------------
module param_select_sorter #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          descend,
    output logic          ready,
    output logic          done,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  datain,
    output logic [W-1:0]  dataout
`ifdef SORTER_SWAPCNT_EN
    ,
    output logic [AW:0]   swaps
`endif
);

    localparam int            DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST  = {AW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OUTER = 3'd1,
        S_INNER = 3'd2,
        S_ENDIN = 3'd3,
        S_SWAP  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] i_r;
    logic [AW-1:0] j_r;
    logic [AW-1:0] m_r;
    logic [W-1:0]  best_r;
    logic          desc_r;
    logic          ready_r;
    logic          done_r;
    logic [W-1:0]  dataout_r;
    logic [AW:0]   swaps_r;

    logic          idle_s;
    logic          host_wr_s;
    logic          better_s;

    // Strict comparison: equal values never replace the current best, so
    // ties keep the first-found index and sorted input performs no swaps.
    function automatic logic is_better(input logic [W-1:0] cand,
                                       input logic [W-1:0] best,
                                       input logic         desc);
        if (desc) begin
            return (cand > best);
        end else begin
            return (cand < best);
        end
    endfunction

    assign idle_s    = (state_r == S_IDLE);
    assign host_wr_s = idle_s && wr && !start;   // start wins over a write
    assign better_s  = is_better(mem_r[j_r], best_r, desc_r);

    assign ready   = ready_r;
    assign done    = done_r;
    assign dataout = dataout_r;
`ifdef SORTER_SWAPCNT_EN
    assign swaps   = swaps_r;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_OUTER;
                else       state_s = S_IDLE;
            end
            S_OUTER: begin
                // Last-index check comes before any increment of i.
                if (i_r == LAST) state_s = S_IDLE;
                else             state_s = S_INNER;
            end
            S_INNER: begin
                if (j_r == LAST) state_s = S_ENDIN;
                else             state_s = S_INNER;
            end
            S_ENDIN: begin
                if (m_r == i_r) state_s = S_OUTER;
                else            state_s = S_SWAP;
            end
            S_SWAP:  state_s = S_OUTER;
            default: state_s = S_IDLE;
        endcase
    end

    // Data path: indices, running best, host read port and status outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i_r       <= '0;
            j_r       <= '0;
            m_r       <= '0;
            best_r    <= '0;
            desc_r    <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            dataout_r <= '0;
            swaps_r   <= '0;
        end else begin
            ready_r <= (state_s == S_IDLE);
            done_r  <= (state_r == S_OUTER) && (i_r == LAST);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        desc_r  <= descend;
                        i_r     <= '0;
                        swaps_r <= '0;
                    end else begin
                        dataout_r <= mem_r[addr];
                    end
                end
                S_OUTER: begin
                    if (i_r != LAST) begin
                        j_r    <= i_r + 1'b1;
                        m_r    <= i_r;
                        best_r <= mem_r[i_r];
                    end
                end
                S_INNER: begin
                    if (better_s) begin
                        m_r    <= j_r;
                        best_r <= mem_r[j_r];
                    end
                    if (j_r != LAST) begin
                        j_r <= j_r + 1'b1;
                    end
                end
                S_ENDIN: begin
                    if (m_r == i_r) begin
                        i_r <= i_r + 1'b1;
                    end
                end
                S_SWAP: begin
                    i_r     <= i_r + 1'b1;
                    swaps_r <= swaps_r + 1'b1;
                end
                default: begin
                    i_r <= '0;
                end
            endcase
        end
    end

    // Memory array: host writes while idle, both swap writes in one SWAP cycle
    // (m != i is guaranteed there, and the right side reads pre-edge values).
    always_ff @(posedge clk) begin
        if (host_wr_s) begin
            mem_r[addr] <= datain;
        end else if (state_r == S_SWAP) begin
            mem_r[i_r] <= best_r;
            mem_r[m_r] <= mem_r[i_r];
        end
    end

endmodule

// File: tb/tb_param_select_sorter.sv
// -----------------------------------------------------------------------------
// tb_param_select_sorter
//
// Two instances: a default 8x8 sorter (A) and a W=12, AW=1 sorter (B).
// Reads push hand-computed expected data into per-instance queues; monitors
// pop and compare on the cycle the registered read data appears.
// -----------------------------------------------------------------------------
module tb_param_select_sorter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    logic        a_start, a_descend, a_wr, a_ready, a_done;
    logic [2:0]  a_addr;
    logic [7:0]  a_din, a_dout;
    logic        b_start, b_descend, b_wr, b_ready, b_done;
    logic [0:0]  b_addr;
    logic [11:0] b_din, b_dout;
`ifdef SORTER_SWAPCNT_EN
    logic [3:0]  a_swaps;
    logic [1:0]  b_swaps;
`endif

    param_select_sorter #(.W(8), .AW(3)) dut_a (
        .clk(clk), .nrst(nrst), .start(a_start), .descend(a_descend),
        .ready(a_ready), .done(a_done), .wr(a_wr), .addr(a_addr),
        .datain(a_din), .dataout(a_dout)
`ifdef SORTER_SWAPCNT_EN
        , .swaps(a_swaps)
`endif
    );

    param_select_sorter #(.W(12), .AW(1)) dut_b (
        .clk(clk), .nrst(nrst), .start(b_start), .descend(b_descend),
        .ready(b_ready), .done(b_done), .wr(b_wr), .addr(b_addr),
        .datain(b_din), .dataout(b_dout)
`ifdef SORTER_SWAPCNT_EN
        , .swaps(b_swaps)
`endif
    );

    int total = 0;
    int bad   = 0;
    int exp_a[$];
    int exp_b[$];
    logic a_rd_req = 1'b0, a_rd_v = 1'b0;
    logic b_rd_req = 1'b0, b_rd_v = 1'b0;

    int din_v[8]  = '{5, 3, 7, 0, 255, 3, 1, 9};
    int asc_v[8]  = '{0, 1, 3, 3, 5, 7, 9, 255};
    int desc_v[8] = '{255, 9, 7, 5, 3, 3, 1, 0};

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // read-valid tracks the one-cycle read latency of each instance
    always @(posedge clk) begin
        a_rd_v <= a_rd_req;
        b_rd_v <= b_rd_req;
    end

    // monitor A
    always @(negedge clk) begin
        if (a_rd_v) begin
            if (exp_a.size() == 0) chk("a_unexpected_read", 1, 0);
            else chk("a_read", a_dout, exp_a.pop_front());
        end
    end

    // monitor B
    always @(negedge clk) begin
        if (b_rd_v) begin
            if (exp_b.size() == 0) chk("b_unexpected_read", 1, 0);
            else chk("b_read", b_dout, exp_b.pop_front());
        end
    end

    task automatic a_write(input int ad, input int d);
        a_wr = 1'b1; a_addr = ad[2:0]; a_din = d[7:0];
        @(posedge clk); #1;
        a_wr = 1'b0;
    endtask

    task automatic a_read(input int ad, input int e);
        a_addr = ad[2:0]; a_rd_req = 1'b1; exp_a.push_back(e);
        @(posedge clk); #1;
        a_rd_req = 1'b0;
    endtask

    task automatic b_write(input int ad, input int d);
        b_wr = 1'b1; b_addr = ad[0:0]; b_din = d[11:0];
        @(posedge clk); #1;
        b_wr = 1'b0;
    endtask

    task automatic b_read(input int ad, input int e);
        b_addr = ad[0:0]; b_rd_req = 1'b1; exp_b.push_back(e);
        @(posedge clk); #1;
        b_rd_req = 1'b0;
    endtask

    task automatic a_sort(input logic d, input int budget);
        int cyc;
        logic seen;
        a_start = 1'b1; a_descend = d;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_busy_ready", a_ready, 0);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (a_done) seen = 1'b1;
        end
        chk("a_done_seen", seen, 1);
        chk("a_ready_at_done", a_ready, 1);
        @(negedge clk);
        chk("a_done_one_cycle", a_done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cap[8];
        int tmp;
        int cyc;
        logic seen;
        nrst = 1'b0;
        a_start = 1'b0; a_descend = 1'b0; a_wr = 1'b0; a_addr = '0; a_din = '0;
        b_start = 1'b0; b_descend = 1'b0; b_wr = 1'b0; b_addr = '0; b_din = '0;

        // reset values
        @(negedge clk);
        chk("a_rst_ready", a_ready, 1);
        chk("a_rst_done", a_done, 0);
        chk("a_rst_dout", a_dout, 0);
        chk("b_rst_ready", b_ready, 1);
        chk("b_rst_dout", b_dout, 0);
`ifdef SORTER_SWAPCNT_EN
        chk("a_rst_swaps", a_swaps, 0);
`endif
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // load and read back
        for (int k = 0; k < 8; k++) a_write(k, din_v[k]);
        for (int k = 0; k < 8; k++) a_read(k, din_v[k]);

        // ascending
        a_sort(1'b0, 100);
        for (int k = 0; k < 8; k++) a_read(k, asc_v[k]);
`ifdef SORTER_SWAPCNT_EN
        chk("a_swaps_asc", a_swaps, 6);
`endif

        // descending on the now-ascending data
        a_sort(1'b1, 100);
        for (int k = 0; k < 8; k++) a_read(k, desc_v[k]);
`ifdef SORTER_SWAPCNT_EN
        chk("a_swaps_desc", a_swaps, 4);
`endif

        // already sorted input
        for (int k = 0; k < 8; k++) a_write(k, k);
        a_sort(1'b0, 100);
        for (int k = 0; k < 8; k++) a_read(k, k);
`ifdef SORTER_SWAPCNT_EN
        chk("a_swaps_sorted", a_swaps, 0);
`endif

        // reset in the middle of a sort
        for (int k = 0; k < 8; k++) a_write(k, din_v[k]);
        a_start = 1'b1; a_descend = 1'b0;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("a_midrst_ready", a_ready, 1);
        chk("a_midrst_done", a_done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("a_midrst_no_done", a_done, 0);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a_addr = k[2:0];
            @(posedge clk); #1;
            cap[k] = int'(a_dout);
        end
        for (int x = 0; x < 7; x++) begin
            for (int y = 0; y < 7 - x; y++) begin
                if (cap[y] > cap[y+1]) begin
                    tmp = cap[y]; cap[y] = cap[y+1]; cap[y+1] = tmp;
                end
            end
        end
        for (int k = 0; k < 8; k++) chk("a_midrst_perm", cap[k], asc_v[k]);
        a_sort(1'b0, 100);
        for (int k = 0; k < 8; k++) a_read(k, asc_v[k]);

        // W=12, AW=1, with wr/start pulsed while busy
        b_write(0, 4095);
        b_write(1, 0);
        b_read(0, 4095);
        b_read(1, 0);
        b_start = 1'b1; b_descend = 1'b0;
        @(posedge clk); #1;
        b_start = 1'b1; b_wr = 1'b1; b_addr = 1'b0; b_din = 12'd123;
        @(posedge clk); #1;
        b_start = 1'b0; b_wr = 1'b0;
        chk("b_busy_ready", b_ready, 0);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (b_done) seen = 1'b1;
        end
        chk("b_done_seen", seen, 1);
        @(posedge clk); #1;
        b_read(0, 0);
        b_read(1, 4095);
        chk("b_ready_after", b_ready, 1);
`ifdef SORTER_SWAPCNT_EN
        chk("b_swaps", b_swaps, 1);
`endif

        repeat (3) @(posedge clk);
        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_select_sorter.md
Name: param_select_sorter

Overview:
- Parametrised in-place selection sorter: the successor to our fixed 8x8-bit sorter.
- Owns a DEPTH-entry, W-bit register-array memory, loaded and read by the host through an addr/wr port while idle.
- On start, sorts the memory ascending or descending (selected per run), then returns to ready.
- Sits as a standalone accelerator next to the host controller; uses a state-path / data-path split internally.

Parameters:
W, 8, data word width in bits (>=1)
AW, 3, address width; DEPTH = 2**AW entries (AW>=1)

Ports:
clk  input  1  clock, all state changes on posedge
nrst  input  1  asynchronous active-low reset
start  input  1  begin sort; honoured only when ready=1
descend  input  1  0 = ascending, 1 = descending; sampled with start
ready  output  1  1 = idle, host port active
done  output  1  one-cycle pulse on the cycle ready returns to 1 after a sort
wr  input  1  host write strobe; honoured only when ready=1
addr  input  AW  host read/write address
datain  input  W  host write data
dataout  output  W  registered host read data

Behaviour:
- Reset: clk and nrst as decided (asynchronous, active-low reset nrst; clock clk).
- Reset values: ready=1, done=0, dataout=0, FSM=IDLE. Memory is not reset; contents are unspecified after reset.
- Idle host port (ready=1, start=0):
  - wr=1: mem[addr] <= datain at posedge.
  - dataout <= mem[addr] every posedge. Read latency is 1 cycle.
  - Same-cycle wr and read to the same addr returns the OLD value.
- start with wr in the same cycle: start wins and the write is dropped.
- On start while ready=1: next cycle ready=0, descend latched, i=0. start is ignored when ready=0.
- Busy: wr, addr and datain are ignored; dataout holds its last value.
- FSM states:
  - IDLE: start -> OUTER.
  - OUTER: if i==DEPTH-1 -> IDLE (ready=1, done=1 for 1 cycle). Else j=i+1, m=i, issue read of mem[i] -> INNER.
  - INNER: one j per cycle over i+1..DEPTH-1. Compare mem[j] against the current best value. Update m,best when strictly less (ascending) or strictly greater (descending). After j==DEPTH-1 -> ENDIN.
  - ENDIN: m==i -> OUTER with i+1. Else -> SWAP.
  - SWAP: writes mem[i] <= best and mem[m] <= old mem[i] (two writes, one or two cycles at implementer's choice), then i+1 -> OUTER.
- Equal values never swap, and ties keep the first-found index.
- Output ordering of equal values is irrelevant; only the value multiset and the order are checked.
- Total sort latency, start to done: at most DEPTH*(DEPTH+4)+4 cycles.
- Already-sorted input performs zero swaps.
- All comparisons are unsigned, W bits. Index counters are AW bits and must not wrap: the i==DEPTH-1 check precedes any increment.
- nrst asserted mid-sort: immediate return to IDLE, ready=1, no done pulse. Memory holds a partially sorted permutation (no data lost beyond a write interrupted in SWAP).
- DEPTH=2 (AW=1) must work: a single comparison, at most one swap.

Optional Feature:
- Macro: SORTER_SWAPCNT_EN.
- Defined: extra output swaps, width AW+1, counting swaps performed in the current/last sort.
  - Cleared on the cycle after an accepted start; increments once per SWAP.
  - Holds after done until the next start; reset value 0.
- Undefined: the port and counter are absent; everything else is identical.

Test Plan:
- Reset, then write 8 words {5,3,7,0,255,3,1,9}, read back addrs 0..7 -> dataout equals written values one cycle after each addr.
- Same data, start with descend=0 -> done pulse within 100 cycles; readback {0,1,3,3,5,7,9,255}; swaps (if enabled) nonzero.
- Same data, start with descend=1 -> readback {255,9,7,5,3,3,1,0}.
- Preloaded {0,1,2,..,7} ascending -> sorted unchanged, swaps=0.
- start, assert nrst low 10 cycles into the sort -> ready=1 immediately, no done. Readback is a permutation of the input; a new sort then completes correctly.
- W=12, AW=1: data {4095,0}, ascending -> {0,4095}. wr and start pulsed during busy -> ignored, memory unaffected.
